// File: rtl/fusion_retire_split.sv
// Splits committed ADD+LOAD fused entries back into two precise retire beats.
// Non-fused entries pass through as a single beat.
module fusion_retire_split #(
  parameter int VLEN = 64,
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            commit_valid_i,
  output logic            commit_ready_o,
  input  logic [VLEN-1:0] commit_pc_i,
  input  logic [1:0]      commit_is_fusion_i,
  input  logic            commit_is_compressed_i,
  input  logic [4:0]      commit_rd_i,
  input  logic [XLEN-1:0] commit_add_result_i,
  input  logic            commit_ex_valid_i,
  input  logic [XLEN-1:0] commit_ex_cause_i,
  input  logic [XLEN-1:0] commit_ex_tval_i,
  output logic            retire_valid_o,
  input  logic            retire_ready_i,
  output logic [VLEN-1:0] retire_pc_o,
  output logic            retire_is_compressed_o,
  output logic            retire_ex_valid_o,
  output logic [XLEN-1:0] retire_ex_cause_o,
  output logic [XLEN-1:0] retire_ex_tval_o,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o
);

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    FIRST,
    SECOND
  } state_t;

  state_t          state;
  logic [VLEN-1:0] pc_q;
  logic [1:0]      fus_q;
  logic            c_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] add_q;
  logic            ex_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;

  logic            last;
  logic            acc;
  logic            hs;
  logic [VLEN-1:0] off;

  assign last = (state == SINGLE) || (state == SECOND);
  assign commit_ready_o = ~rst_i & ~flush_i &
    ((state == IDLE) | (last & retire_ready_i));
  assign acc = commit_valid_i & commit_ready_o;
  assign hs  = retire_valid_o & retire_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pc_q    <= '0;
      fus_q   <= '0;
      c_q     <= 1'b0;
      rd_q    <= '0;
      add_q   <= '0;
      ex_q    <= 1'b0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      if (acc) begin
        pc_q    <= commit_pc_i;
        fus_q   <= commit_is_fusion_i;
        c_q     <= commit_is_compressed_i;
        rd_q    <= commit_rd_i;
        add_q   <= commit_add_result_i;
        ex_q    <= commit_ex_valid_i;
        cause_q <= commit_ex_cause_i;
        tval_q  <= commit_ex_tval_i;
      end
      if (flush_i) begin
        state <= IDLE;
      end else if (acc) begin
        state <= (commit_is_fusion_i == 2'b00) ? SINGLE : FIRST;
      end else if (hs) begin
        state <= (state == FIRST) ? SECOND : IDLE;
      end
    end
  end

  // LOAD half sits after a 2-byte or 4-byte ADD half
  assign off = ((fus_q == 2'b11) || (fus_q == 2'b10 && c_q)) ?
    VLEN'(4) : VLEN'(2);

  always_comb begin
    retire_valid_o         = 1'b0;
    retire_pc_o            = '0;
    retire_is_compressed_o = 1'b0;
    retire_ex_valid_o      = 1'b0;
    retire_ex_cause_o      = '0;
    retire_ex_tval_o       = '0;
    wb_valid_o             = 1'b0;
    wb_rd_o                = '0;
    wb_data_o              = '0;
    unique case (state)
      SINGLE: begin
        retire_valid_o         = 1'b1;
        retire_pc_o            = pc_q;
        retire_is_compressed_o = c_q;
        retire_ex_valid_o      = ex_q;
        retire_ex_cause_o      = cause_q;
        retire_ex_tval_o       = tval_q;
      end
      FIRST: begin
        retire_valid_o         = 1'b1;
        retire_pc_o            = pc_q;
        retire_is_compressed_o = (fus_q == 2'b01) |
          ((fus_q == 2'b10) & ~c_q);
        wb_valid_o             = ex_q;
        wb_rd_o                = ex_q ? rd_q : '0;
        wb_data_o              = ex_q ? add_q : '0;
      end
      SECOND: begin
        retire_valid_o         = 1'b1;
        retire_pc_o            = pc_q + off;
        retire_is_compressed_o = (fus_q == 2'b01) |
          ((fus_q == 2'b10) & c_q);
        retire_ex_valid_o      = ex_q;
        retire_ex_cause_o      = cause_q;
        retire_ex_tval_o       = tval_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fusion_retire_split.sv
// Directed bench for fusion_retire_split: 64-bit instance plus a
// 32-bit PC instance sharing the same stimulus for wrap-around.
module tb_fusion_retire_split;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        commit_valid_i = 1'b0;
  logic        commit_ready_o;
  logic [63:0] commit_pc_i = '0;
  logic [1:0]  commit_is_fusion_i = '0;
  logic        commit_is_compressed_i = 1'b0;
  logic [4:0]  commit_rd_i = '0;
  logic [63:0] commit_add_result_i = '0;
  logic        commit_ex_valid_i = 1'b0;
  logic [63:0] commit_ex_cause_i = '0;
  logic [63:0] commit_ex_tval_i = '0;
  logic        retire_valid_o;
  logic        retire_ready_i = 1'b1;
  logic [63:0] retire_pc_o;
  logic        retire_is_compressed_o;
  logic        retire_ex_valid_o;
  logic [63:0] retire_ex_cause_o;
  logic [63:0] retire_ex_tval_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_data_o;

  logic        r32_commit_ready;
  logic        r32_valid;
  logic [31:0] r32_pc;
  logic        r32_c;
  logic        r32_exv;
  logic [63:0] r32_cause;
  logic [63:0] r32_tval;
  logic        r32_wbv;
  logic [4:0]  r32_wbrd;
  logic [63:0] r32_wbdata;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fusion_retire_split #(.VLEN(64), .XLEN(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
    .commit_pc_i(commit_pc_i), .commit_is_fusion_i(commit_is_fusion_i),
    .commit_is_compressed_i(commit_is_compressed_i),
    .commit_rd_i(commit_rd_i), .commit_add_result_i(commit_add_result_i),
    .commit_ex_valid_i(commit_ex_valid_i),
    .commit_ex_cause_i(commit_ex_cause_i),
    .commit_ex_tval_i(commit_ex_tval_i),
    .retire_valid_o(retire_valid_o), .retire_ready_i(retire_ready_i),
    .retire_pc_o(retire_pc_o),
    .retire_is_compressed_o(retire_is_compressed_o),
    .retire_ex_valid_o(retire_ex_valid_o),
    .retire_ex_cause_o(retire_ex_cause_o),
    .retire_ex_tval_o(retire_ex_tval_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
  );

  fusion_retire_split #(.VLEN(32), .XLEN(64)) dut32 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .commit_valid_i(commit_valid_i), .commit_ready_o(r32_commit_ready),
    .commit_pc_i(commit_pc_i[31:0]),
    .commit_is_fusion_i(commit_is_fusion_i),
    .commit_is_compressed_i(commit_is_compressed_i),
    .commit_rd_i(commit_rd_i), .commit_add_result_i(commit_add_result_i),
    .commit_ex_valid_i(commit_ex_valid_i),
    .commit_ex_cause_i(commit_ex_cause_i),
    .commit_ex_tval_i(commit_ex_tval_i),
    .retire_valid_o(r32_valid), .retire_ready_i(retire_ready_i),
    .retire_pc_o(r32_pc), .retire_is_compressed_o(r32_c),
    .retire_ex_valid_o(r32_exv), .retire_ex_cause_o(r32_cause),
    .retire_ex_tval_o(r32_tval),
    .wb_valid_o(r32_wbv), .wb_rd_o(r32_wbrd), .wb_data_o(r32_wbdata)
  );

  task automatic drive(input logic [1:0] f, input logic [63:0] pc,
                       input logic c, input logic [4:0] rd,
                       input logic [63:0] add, input logic exv,
                       input logic [63:0] cause, input logic [63:0] tval);
    commit_valid_i         = 1'b1;
    commit_is_fusion_i     = f;
    commit_pc_i            = pc;
    commit_is_compressed_i = c;
    commit_rd_i            = rd;
    commit_add_result_i    = add;
    commit_ex_valid_i      = exv;
    commit_ex_cause_i      = cause;
    commit_ex_tval_i       = tval;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", commit_ready_o); end
    n_checks++; if (retire_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", retire_valid_o); end
    n_checks++; if (retire_pc_o !== 64'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", retire_pc_o); end
    n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_wb got %b exp 0", wb_valid_o); end
    rst_i = 1'b0;
    #1;
    n_checks++; if (commit_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b exp 1", commit_ready_o); end
  endtask

  task automatic test_single;
    @(negedge clk);
    drive(2'b00, 64'h8000_0000, 1'b0, 5'd3, 64'h0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    commit_valid_i = 1'b0;
    #1;
    n_checks++; if (retire_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", retire_valid_o); end
    n_checks++; if (retire_pc_o !== 64'h8000_0000) begin n_fail++; $display("FAIL single_pc got %h exp 80000000", retire_pc_o); end
    n_checks++; if (retire_is_compressed_o !== 1'b0) begin n_fail++; $display("FAIL single_c got %b exp 0", retire_is_compressed_o); end
    n_checks++; if (retire_ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_ex got %b exp 0", retire_ex_valid_o); end
    n_checks++; if (commit_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", commit_ready_o); end
    @(negedge clk);
    n_checks++; if (retire_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_done got %b exp 0", retire_valid_o); end
  endtask

  task automatic test_fused11;
    @(negedge clk);
    drive(2'b11, 64'h1000, 1'b0, 5'd4, 64'h55, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    commit_valid_i = 1'b0;
    #1;
    n_checks++; if (retire_valid_o !== 1'b1) begin n_fail++; $display("FAIL f11_v1 got %b exp 1", retire_valid_o); end
    n_checks++; if (retire_pc_o !== 64'h1000) begin n_fail++; $display("FAIL f11_pc1 got %h exp 1000", retire_pc_o); end
    n_checks++; if (retire_is_compressed_o !== 1'b0) begin n_fail++; $display("FAIL f11_c1 got %b exp 0", retire_is_compressed_o); end
    n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL f11_wb1 got %b exp 0", wb_valid_o); end
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fail++; $display("FAIL f11_ready1 got %b exp 0", commit_ready_o); end
    @(negedge clk);
    n_checks++; if (retire_pc_o !== 64'h1004) begin n_fail++; $display("FAIL f11_pc2 got %h exp 1004", retire_pc_o); end
    n_checks++; if (retire_is_compressed_o !== 1'b0) begin n_fail++; $display("FAIL f11_c2 got %b exp 0", retire_is_compressed_o); end
    n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL f11_wb2 got %b exp 0", wb_valid_o); end
    @(negedge clk);
    n_checks++; if (retire_valid_o !== 1'b0) begin n_fail++; $display("FAIL f11_done got %b exp 0", retire_valid_o); end
  endtask

  task automatic test_fused10;
    logic        cin [2]  = '{1'b1, 1'b0};
    logic        c1  [2]  = '{1'b0, 1'b1};
    logic [63:0] pc2 [2]  = '{64'h2004, 64'h2002};
    logic        c2  [2]  = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(2'b10, 64'h2000, cin[i], 5'd1, 64'h0, 1'b0, 64'h0, 64'h0);
      @(negedge clk);
      commit_valid_i = 1'b0;
      n_checks++; if (retire_pc_o !== 64'h2000) begin n_fail++; $display("FAIL f10_pc1[%0d] got %h exp 2000", i, retire_pc_o); end
      n_checks++; if (retire_is_compressed_o !== c1[i]) begin n_fail++; $display("FAIL f10_c1[%0d] got %b exp %b", i, retire_is_compressed_o, c1[i]); end
      @(negedge clk);
      n_checks++; if (retire_pc_o !== pc2[i]) begin n_fail++; $display("FAIL f10_pc2[%0d] got %h exp %h", i, retire_pc_o, pc2[i]); end
      n_checks++; if (retire_is_compressed_o !== c2[i]) begin n_fail++; $display("FAIL f10_c2[%0d] got %b exp %b", i, retire_is_compressed_o, c2[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_fused01_ex;
    @(negedge clk);
    drive(2'b01, 64'h3000, 1'b1, 5'd10, 64'h1234, 1'b1, 64'd5, 64'hdead);
    @(negedge clk);
    commit_valid_i = 1'b0;
    n_checks++; if (retire_pc_o !== 64'h3000) begin n_fail++; $display("FAIL f01_pc1 got %h exp 3000", retire_pc_o); end
    n_checks++; if (retire_is_compressed_o !== 1'b1) begin n_fail++; $display("FAIL f01_c1 got %b exp 1", retire_is_compressed_o); end
    n_checks++; if (retire_ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL f01_ex1 got %b exp 0", retire_ex_valid_o); end
    n_checks++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL f01_wbv got %b exp 1", wb_valid_o); end
    n_checks++; if (wb_rd_o !== 5'd10) begin n_fail++; $display("FAIL f01_wbrd got %0d exp 10", wb_rd_o); end
    n_checks++; if (wb_data_o !== 64'h1234) begin n_fail++; $display("FAIL f01_wbdata got %h exp 1234", wb_data_o); end
    @(negedge clk);
    n_checks++; if (retire_pc_o !== 64'h3002) begin n_fail++; $display("FAIL f01_pc2 got %h exp 3002", retire_pc_o); end
    n_checks++; if (retire_is_compressed_o !== 1'b1) begin n_fail++; $display("FAIL f01_c2 got %b exp 1", retire_is_compressed_o); end
    n_checks++; if (retire_ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL f01_ex2 got %b exp 1", retire_ex_valid_o); end
    n_checks++; if (retire_ex_cause_o !== 64'd5) begin n_fail++; $display("FAIL f01_cause got %h exp 5", retire_ex_cause_o); end
    n_checks++; if (retire_ex_tval_o !== 64'hdead) begin n_fail++; $display("FAIL f01_tval got %h exp dead", retire_ex_tval_o); end
    n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL f01_wb2 got %b exp 0", wb_valid_o); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(2'b11, 64'h4000, 1'b0, 5'd2, 64'h0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    commit_valid_i = 1'b0;
    n_checks++; if (retire_pc_o !== 64'h4000) begin n_fail++; $display("FAIL bp_pc1 got %h exp 4000", retire_pc_o); end
    @(negedge clk);
    retire_ready_i = 1'b0;
    drive(2'b00, 64'h5000, 1'b1, 5'd2, 64'h0, 1'b0, 64'h0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (retire_valid_o !== 1'b1 || retire_pc_o !== 64'h4004) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b pc=%h exp v=1 pc=4004", k, retire_valid_o, retire_pc_o); end
      n_checks++; if (commit_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", k, commit_ready_o); end
      @(negedge clk);
    end
    retire_ready_i = 1'b1;
    #1;
    n_checks++; if (retire_pc_o !== 64'h4004) begin n_fail++; $display("FAIL bp_release_pc got %h exp 4004", retire_pc_o); end
    n_checks++; if (commit_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", commit_ready_o); end
    @(negedge clk);
    commit_valid_i = 1'b0;
    n_checks++; if (retire_valid_o !== 1'b1 || retire_pc_o !== 64'h5000) begin n_fail++; $display("FAIL b2b_pc got v=%b pc=%h exp v=1 pc=5000", retire_valid_o, retire_pc_o); end
    n_checks++; if (retire_is_compressed_o !== 1'b1) begin n_fail++; $display("FAIL b2b_c got %b exp 1", retire_is_compressed_o); end
    @(negedge clk);
    n_checks++; if (retire_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done got %b exp 0", retire_valid_o); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    drive(2'b11, 64'h6000, 1'b0, 5'd2, 64'h0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    commit_valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    n_checks++; if (retire_pc_o !== 64'h6000) begin n_fail++; $display("FAIL fl_pc1 got %h exp 6000", retire_pc_o); end
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fail++; $display("FAIL fl_ready got %b exp 0", commit_ready_o); end
    @(negedge clk);
    flush_i = 1'b0;
    n_checks++; if (retire_valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_nosecond got %b exp 0", retire_valid_o); end
    @(negedge clk);
    n_checks++; if (retire_valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_idle got %b exp 0", retire_valid_o); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(2'b01, 64'h7000, 1'b1, 5'd7, 64'h77, 1'b1, 64'd2, 64'hbeef);
    @(negedge clk);
    commit_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fail++; $display("FAIL rm_ready got %b exp 0", commit_ready_o); end
    @(negedge clk);
    n_checks++; if ({retire_valid_o, wb_valid_o, retire_is_compressed_o, retire_ex_valid_o} !== 4'b0) begin n_fail++; $display("FAIL rm_flags got %b exp 0000", {retire_valid_o, wb_valid_o, retire_is_compressed_o, retire_ex_valid_o}); end
    n_checks++; if ({retire_pc_o, retire_ex_cause_o, retire_ex_tval_o, wb_data_o} !== 256'h0 || wb_rd_o !== 5'd0) begin n_fail++; $display("FAIL rm_data got pc=%h cause=%h tval=%h rd=%0d data=%h exp all 0", retire_pc_o, retire_ex_cause_o, retire_ex_tval_o, wb_rd_o, wb_data_o); end
    rst_i = 1'b0;
    @(negedge clk);
    n_checks++; if (retire_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_idle got %b exp 0", retire_valid_o); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    drive(2'b01, 64'h0000_0000_FFFF_FFFE, 1'b1, 5'd1, 64'h0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    commit_valid_i = 1'b0;
    n_checks++; if (r32_pc !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap32_pc1 got %h exp fffffffe", r32_pc); end
    @(negedge clk);
    n_checks++; if (r32_valid !== 1'b1 || r32_pc !== 32'h0) begin n_fail++; $display("FAIL wrap32_pc2 got v=%b pc=%h exp v=1 pc=0", r32_valid, r32_pc); end
    n_checks++; if (retire_pc_o !== 64'h1_0000_0000) begin n_fail++; $display("FAIL wrap64_carry got %h exp 100000000", retire_pc_o); end
    @(negedge clk);
    drive(2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5'd1, 64'h0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    commit_valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (retire_pc_o !== 64'h2) begin n_fail++; $display("FAIL wrap64_pc2 got %h exp 2", retire_pc_o); end
    n_checks++; if (r32_pc !== 32'h2) begin n_fail++; $display("FAIL wrap32_f11 got %h exp 2", r32_pc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_fused11;
    test_fused10;
    test_fused01_ex;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
